// File: rtl/op_dispatcher.sv
// Opcode dispatcher: latches one decoded opcode as the chooser select, runs the
// handler trigger/rdy/done handshake, counts completions and watches for hung handlers.
package Op_PKG;
  typedef struct packed {
    logic [7:0]  cmd;   // G-code number, e.g. 8'd1 for G01
    logic [15:0] arg;
  } Op_st;
endpackage

module op_dispatcher
  import Op_PKG::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  input  Op_st                 op_in,
  output logic                 op_rd,
  output Op_st                 op,
  output logic                 trigger,
  input  logic                 rdy,
  input  logic                 done,
  output logic                 busy,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] op_cnt
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT_RDY, WAIT_DONE} state_t;

  state_t                state, state_nx;
  Op_st                  op_nx;
  logic                  op_rd_nx, trigger_nx, busy_nx, timeout_nx;
  logic [CNT_WIDTH-1:0]  op_cnt_nx;
  logic [WD_W-1:0]       wd, wd_nx;

  always_comb begin
    state_nx   = state;
    op_nx      = op;
    op_rd_nx   = 1'b0;
    trigger_nx = 1'b0;
    timeout_nx = timeout;
    op_cnt_nx  = op_cnt;
    wd_nx      = wd;
    case (state)
      IDLE: begin
        wd_nx = '0;
        // a sticky timeout freezes loading until reset
        if (op_valid && !timeout) begin
          op_nx    = op_in;
          op_rd_nx = 1'b1;
          state_nx = SETTLE;
        end
      end
      // chooser needs one cycle to re-route rdy to the new handler
      SETTLE: state_nx = WAIT_RDY;
      WAIT_RDY: begin
        if (rdy) begin
          trigger_nx = 1'b1;
          wd_nx      = '0;
          state_nx   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wd_nx = wd + 1'b1;
        // done takes priority over a watchdog expiry in the same cycle
        if (done) begin
          op_cnt_nx = op_cnt + 1'b1;
          state_nx  = IDLE;
        end else if (WD_EN && (wd == WD_LAST)) begin
          timeout_nx = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      op      <= '0;
      op_rd   <= 1'b0;
      trigger <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      op_cnt  <= '0;
      wd      <= '0;
    end else begin
      state   <= state_nx;
      op      <= op_nx;
      op_rd   <= op_rd_nx;
      trigger <= trigger_nx;
      busy    <= busy_nx;
      timeout <= timeout_nx;
      op_cnt  <= op_cnt_nx;
      wd      <= wd_nx;
    end
  end

endmodule

// File: tb/tb_op_dispatcher.sv
// Bench for op_dispatcher: directed handshake scenarios plus random traffic, two DUTs
// (16- and 2-bit counters) compared every cycle against a sequential protocol model.
module tb_op_dispatcher;
  import Op_PKG::*;

  localparam int TO = 8;

  logic clk = 1'b0, reset = 1'b1;
  logic op_valid = 1'b0, rdy = 1'b0, done = 1'b0;
  Op_st op_in = '0;

  logic op_rd_a, trig_a, busy_a, to_a;
  Op_st op_a;
  logic [15:0] cnt_a;
  logic op_rd_b, trig_b, busy_b, to_b;
  Op_st op_b;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  op_dispatcher #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_in(op_in), .op_rd(op_rd_a),
    .op(op_a), .trigger(trig_a), .rdy(rdy), .done(done), .busy(busy_a),
    .timeout(to_a), .op_cnt(cnt_a));

  op_dispatcher #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_in(op_in), .op_rd(op_rd_b),
    .op(op_b), .trigger(trig_b), .rdy(rdy), .done(done), .busy(busy_b),
    .timeout(to_b), .op_cnt(cnt_b));

  int n_vec = 0, n_bad = 0, cyc = 0;

  always @(posedge clk) cyc++;

  function automatic Op_st mk(input int cmd);
    Op_st o;
    o.cmd = 8'(cmd);
    o.arg = 16'($urandom);
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one opcode = one sequential transaction
  logic m_rd = 1'b0, m_trig = 1'b0, m_busy = 1'b0, m_to = 1'b0;
  Op_st m_op = '0;
  int unsigned m_cnt = 0;

  always @(negedge reset) begin
    m_rd = 1'b0; m_trig = 1'b0; m_busy = 1'b0; m_to = 1'b0; m_op = '0; m_cnt = 0;
  end

  task automatic model_op();
    int k;
    m_op = op_in; m_rd = 1'b1; m_busy = 1'b1;
    @(posedge clk); if (!reset) return;
    m_rd = 1'b0;
    forever begin
      @(posedge clk); if (!reset) return;
      if (rdy) break;
    end
    m_trig = 1'b1;
    k = 0;
    forever begin
      @(posedge clk); if (!reset) return;
      m_trig = 1'b0;
      k++;
      if (done)    begin m_cnt++;     m_busy = 1'b0; return; end
      if (k == TO) begin m_to = 1'b1; m_busy = 1'b0; return; end
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (reset && !m_to && op_valid) model_op();
  end

  // ---------------- per-cycle compare of both DUTs
  always @(negedge clk) begin
    n_vec++;
    if ({op_rd_a, op_a, trig_a, busy_a, to_a, cnt_a} !==
        {m_rd, m_op, m_trig, m_busy, m_to, m_cnt[15:0]}) begin
      n_bad++;
      $display("FAIL cycle_a t=%0t got rd=%b op=%h trig=%b busy=%b to=%b cnt=%0d expected rd=%b op=%h trig=%b busy=%b to=%b cnt=%0d",
               $time, op_rd_a, op_a, trig_a, busy_a, to_a, cnt_a,
               m_rd, m_op, m_trig, m_busy, m_to, m_cnt[15:0]);
    end
    n_vec++;
    if ({op_rd_b, op_b, trig_b, busy_b, to_b, cnt_b} !==
        {m_rd, m_op, m_trig, m_busy, m_to, m_cnt[1:0]}) begin
      n_bad++;
      $display("FAIL cycle_b t=%0t got rd=%b op=%h trig=%b busy=%b to=%b cnt=%0d expected rd=%b op=%h trig=%b busy=%b to=%b cnt=%0d",
               $time, op_rd_b, op_b, trig_b, busy_b, to_b, cnt_b,
               m_rd, m_op, m_trig, m_busy, m_to, m_cnt[1:0]);
    end
  end

  // ---------------- stimulus helpers
  Op_st fifo[$];
  int   rd_cyc[$];
  int   rd_cmd[$];

  // upstream FIFO: pops whenever the dispatcher reports op_rd
  task automatic feed(input int max_cyc);
    int c = 0;
    op_valid = (fifo.size() != 0);
    if (op_valid) op_in = fifo[0];
    while ((fifo.size() != 0 || busy_a) && c < max_cyc) begin
      @(negedge clk); c++;
      if (op_rd_a) begin
        rd_cyc.push_back(cyc);
        rd_cmd.push_back(int'(op_a.cmd));
        fifo.delete(0);
      end
      op_valid = (fifo.size() != 0);
      if (op_valid) op_in = fifo[0];
    end
    chk("feed_in_budget", 64'(c < max_cyc), 64'd1);
  endtask

  task automatic wait_rd(input string name);
    int c = 0;
    do begin @(negedge clk); c++; end while (!op_rd_a && c < 20);
    chk(name, 64'(op_rd_a), 64'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cnt", 64'(cnt_a), 64'd0);
    chk("rst_to", 64'(to_a), 64'd0);
    @(posedge clk); #2 reset = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    // reset held with an opcode waiting
    op_valid = 1'b1; op_in = mk(1); rdy = 1'b1; done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {op_rd_a, trig_a, busy_a, to_a, op_a, cnt_a}, 64'd0);
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    chk("rd_before_edge", 64'(op_rd_a), 64'd0);
    @(negedge clk);
    chk("first_rd", 64'(op_rd_a), 64'd1);
    chk("op_g01", 64'(op_a.cmd), 64'd1);
    chk("busy_settle", 64'(busy_a), 64'd1);
    op_valid = 1'b0;
    @(negedge clk);
    chk("no_trig_wait_rdy", 64'(trig_a), 64'd0);
    @(negedge clk);
    chk("trig_t3", 64'(trig_a), 64'd1);
    repeat (3) @(negedge clk);
    chk("trig_single", 64'(trig_a), 64'd0);
    chk("cnt_before_done", 64'(cnt_a), 64'd0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("cnt_after_g01", 64'(cnt_a), 64'd1);
    chk("idle_after_g01", 64'(busy_a), 64'd0);

    // back-to-back G00, G02, G90 with rdy/done held high
    done = 1'b1;
    fifo = '{mk(0), mk(2), mk(90)};
    feed(60);
    done = 1'b0;
    chk("b2b_count", 64'(rd_cyc.size()), 64'd3);
    if (rd_cyc.size() == 3) begin
      chk("b2b_gap0", 64'(rd_cyc[1] - rd_cyc[0]), 64'd4);
      chk("b2b_gap1", 64'(rd_cyc[2] - rd_cyc[1]), 64'd4);
      chk("b2b_cmd0", 64'(rd_cmd[0]), 64'd0);
      chk("b2b_cmd1", 64'(rd_cmd[1]), 64'd2);
      chk("b2b_cmd2", 64'(rd_cmd[2]), 64'd90);
    end
    chk("b2b_cnt", 64'(cnt_a), 64'd4);
    chk("b2b_cnt_w2", 64'(cnt_b), 64'd0);

    // rdy low for 10 cycles, spurious done while waiting for rdy
    begin
      int tc = 0;
      rdy = 1'b0; op_valid = 1'b1; op_in = mk(2);
      wait_rd("rd_g02");
      op_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (trig_a) tc++;
        done = (i == 4);
      end
      done = 1'b0;
      chk("no_trig_rdy_low", 64'(tc), 64'd0);
      chk("spurious_done", 64'(cnt_a), 64'd4);
      rdy = 1'b1;
      @(negedge clk);
      chk("trig_after_rdy", 64'(trig_a), 64'd1);
      @(negedge clk);
      chk("trig_once", 64'(trig_a), 64'd0);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      chk("cnt5", 64'(cnt_a), 64'd5);
      chk("cnt5_wrap_w2", 64'(cnt_b), 64'd1);
    end

    // watchdog expiry, then sticky blocking of new loads
    begin
      int rc = 0;
      op_valid = 1'b1; op_in = mk(1);
      wait_rd("rd_to");
      op_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("to_not_yet", 64'(to_a), 64'd0);
      @(negedge clk);
      chk("to_set", 64'(to_a), 64'd1);
      chk("to_idle", 64'(busy_a), 64'd0);
      chk("to_cnt", 64'(cnt_a), 64'd5);
      op_valid = 1'b1;
      repeat (10) begin @(negedge clk); if (op_rd_a) rc++; end
      op_valid = 1'b0;
      chk("to_blocks_rd", 64'(rc), 64'd0);
      pulse_reset();
    end

    // done on the expiry cycle wins
    op_valid = 1'b1; op_in = mk(3);
    wait_rd("rd_tie");
    op_valid = 1'b0;
    repeat (9) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("tie_to", 64'(to_a), 64'd0);
    chk("tie_cnt", 64'(cnt_a), 64'd1);

    // async reset while waiting for done
    op_valid = 1'b1; op_in = mk(1);
    wait_rd("rd_async");
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("async_trig_pre", 64'(trig_a), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_trig", 64'(trig_a), 64'd0);
    chk("async_busy", 64'(busy_a), 64'd0);
    chk("async_cnt", 64'(cnt_a), 64'd0);
    @(posedge clk); #2 reset = 1'b1;

    // random traffic with periodic async resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      op_valid = ($urandom_range(9) < 7);
      op_in    = mk($urandom_range(99));
      rdy      = ($urandom_range(2) != 0);
      done     = ($urandom_range(3) == 0);
      if (i % 250 == 249) begin
        #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
      end
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

endmodule
